// File: rtl/lane_xform_pipe.sv
// lane_xform_pipe: per-lane mode transform (pass/invert/mask/xor) with
// per-lane force-high, followed by a 2-stage valid/ready pipeline.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with in_data
// (NCH lanes of W bits), in_mode, in_mask, in_force; out_valid/out_ready
// with out_lane, out_any, out_all, out_parity; hit_count counts output
// handshakes carrying out_all=1 and saturates at all-ones.
module lane_xform_pipe #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH*W-1:0]   in_data,
  input  logic [1:0]         in_mode,
  input  logic [W-1:0]       in_mask,
  input  logic [NCH-1:0]     in_force,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH*W-1:0]   out_lane,
  output logic [NCH-1:0]     out_any,
  output logic               out_all,
  output logic               out_parity,
  output logic [CNT_W-1:0]   hit_count
);

  logic               s1_v;
  logic [NCH*W-1:0]   s1_lane;
  logic               s1_adv;
  logic               s2_adv;
  logic [NCH*W-1:0]   xf;
  logic [NCH-1:0]     any_n;
  logic               all_n;
  logic               par_n;
  logic               hit;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    xf = '0;
    for (int i = 0; i < NCH; i++) begin
      unique case (in_mode)
        2'b00:   xf[i*W +: W] = in_data[i*W +: W];
        2'b01:   xf[i*W +: W] = ~in_data[i*W +: W];
        2'b10:   xf[i*W +: W] = in_data[i*W +: W] & in_mask;
        default: xf[i*W +: W] = in_data[i*W +: W] ^ in_mask;
      endcase
      if (in_force[i]) xf[i*W +: W] = '1;
    end
  end

  // Reductions are taken from stage 1 so the outputs stay pure registers.
  always_comb begin
    any_n = '0;
    for (int i = 0; i < NCH; i++) begin
      any_n[i] = |s1_lane[i*W +: W];
    end
    all_n = &any_n;
    par_n = ^s1_lane;
  end

  assign hit = out_valid && out_ready && out_all;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s1_lane    <= '0;
      out_valid  <= 1'b0;
      out_lane   <= '0;
      out_any    <= '0;
      out_all    <= 1'b0;
      out_parity <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid  <= s1_v;
        out_lane   <= s1_lane;
        out_any    <= any_n;
        out_all    <= all_n;
        out_parity <= par_n;
      end
      if (s1_adv) begin
        s1_v    <= in_valid;
        s1_lane <= xf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count <= '0;
    end else if (hit && (hit_count != '1)) begin
      hit_count <= hit_count + CNT_W'(1);
    end
  end

endmodule
